// File: rtl/l2_sum_serializer_pkg.sv
// Shared definitions for the level-2 adder consumer of the convolution adder tree.
// Default widths and the serializer state encoding.
package l2_sum_serializer_pkg;

  localparam int L2_DATA_WIDTH = 17;
  localparam int L2_SUM_WIDTH  = L2_DATA_WIDTH + 1;
  localparam int L2_LANES      = 4;
  localparam int L2_IDX_W      = $clog2(L2_LANES);

  typedef enum logic {
    SER_IDLE = 1'b0,
    SER_SEND = 1'b1
  } ser_state_t;

endpackage

// File: rtl/l2_sum_serializer.sv
// Captures a packed vector of level-2 sums and streams it out one lane per beat.
// Vectors arriving while a previous one is still draining are dropped and flagged.
module l2_sum_serializer
  import l2_sum_serializer_pkg::*;
#(
  parameter int DATA_WIDTH = L2_DATA_WIDTH,
  parameter int ARRAY_SIZE = L2_LANES
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 in_valid,
  input  logic [(DATA_WIDTH+1)*ARRAY_SIZE-1:0] in_sums,
  output logic                                 in_ready,
  output logic                                 out_valid,
  input  logic                                 out_ready,
  output logic [DATA_WIDTH:0]                  out_data,
  output logic [$clog2(ARRAY_SIZE)-1:0]        out_index,
  output logic                                 out_last,
  output logic                                 overrun
);

  localparam int SW = DATA_WIDTH + 1;
  localparam int IW = $clog2(ARRAY_SIZE);
  localparam logic [IW-1:0] LAST_LANE = IW'(ARRAY_SIZE - 1);

  ser_state_t                   state_p0, state_nxt;
  logic [IW-1:0]                lane_p0, lane_nxt;
  logic [ARRAY_SIZE-1:0][SW-1:0] cap_p0;
  logic                         overrun_p0;
  logic                         xfer;
  logic                         capture;

  // Output stage: registered state through the lane mux only
  assign out_valid = (state_p0 == SER_SEND);
  assign out_last  = out_valid && (lane_p0 == LAST_LANE);
  assign out_index = lane_p0;
  assign out_data  = out_valid ? cap_p0[lane_p0] : '0;
  assign overrun   = overrun_p0;

  assign xfer     = out_valid && out_ready;
  // Accepting on the last-lane transfer is what allows back-to-back vectors without a bubble
  assign in_ready = !out_valid || (out_last && out_ready);
  assign capture  = in_valid && in_ready;

  always_comb begin
    state_nxt = state_p0;
    lane_nxt  = lane_p0;
    case (state_p0)
      SER_IDLE: begin
        if (in_valid) begin
          state_nxt = SER_SEND;
          lane_nxt  = '0;
        end
      end
      SER_SEND: begin
        if (xfer) begin
          if (out_last) begin
            lane_nxt  = '0;
            state_nxt = in_valid ? SER_SEND : SER_IDLE;
          end else begin
            lane_nxt = lane_p0 + 1'b1;
          end
        end
      end
      default: begin
        state_nxt = SER_IDLE;
        lane_nxt  = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_p0   <= SER_IDLE;
      lane_p0    <= '0;
      overrun_p0 <= 1'b0;
    end else begin
      state_p0 <= state_nxt;
      lane_p0  <= lane_nxt;
      if (in_valid && !in_ready) begin
        overrun_p0 <= 1'b1;
      end
    end
  end

  // Capture stage: only written when a vector is accepted, so an overrun cannot corrupt it
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cap_p0 <= '0;
    end else if (capture) begin
      cap_p0 <= in_sums;
    end
  end

endmodule

// File: tb/tb_l2_sum_serializer.sv
// Scenario and randomized bench for l2_sum_serializer against a queue-based beat model.
module tb_l2_sum_serializer;

  localparam int DW = 17;
  localparam int N  = 4;
  localparam int SW = DW + 1;
  localparam int IW = 2;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          in_valid = 1'b0;
  logic [SW*N-1:0] in_sums = '0;
  logic          out_ready = 1'b0;
  logic          in_ready;
  logic          out_valid;
  logic [SW-1:0] out_data;
  logic [IW-1:0] out_index;
  logic          out_last;
  logic          overrun;

  always #5 clk = ~clk;

  l2_sum_serializer #(.DATA_WIDTH(DW), .ARRAY_SIZE(N)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_sums   (in_sums),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_index (out_index),
    .out_last  (out_last),
    .overrun   (overrun)
  );

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [SW-1:0] data;
    logic [IW-1:0] idx;
  } beat_t;

  // Model: the beats still owed downstream, in order, plus the sticky overrun flag.
  beat_t         mq[$];
  bit            exp_ovr = 1'b0;
  bit            exp_valid, exp_ready, exp_last;
  logic [SW-1:0] exp_data;
  logic [IW-1:0] exp_idx;

  localparam logic [SW*N-1:0] V1 = {18'h3FFFF, 18'h00002, 18'h00001, 18'h00000};
  localparam logic [SW*N-1:0] V2 = {18'h00004, 18'h00003, 18'h00002, 18'h00001};
  localparam logic [SW*N-1:0] V3 = {18'h1AAAA, 18'h1AAAA, 18'h1AAAA, 18'h1AAAA};

  task automatic model_expect();
    exp_valid = (mq.size() != 0);
    exp_data  = exp_valid ? mq[0].data : '0;
    exp_idx   = exp_valid ? mq[0].idx : '0;
    exp_last  = exp_valid && (mq[0].idx == IW'(N - 1));
    exp_ready = (mq.size() == 0) || (mq.size() == 1 && out_ready);
  endtask

  task automatic model_commit();
    bit    rdy;
    beat_t b;
    rdy = exp_ready;
    if (exp_valid && out_ready) void'(mq.pop_front());
    if (in_valid) begin
      if (rdy) begin
        for (int i = 0; i < N; i++) begin
          b.data = in_sums[i*SW +: SW];
          b.idx  = IW'(i);
          mq.push_back(b);
        end
      end else begin
        exp_ovr = 1'b1;
      end
    end
  endtask

  task automatic drive(input bit v, input logic [SW*N-1:0] s, input bit r);
    in_valid  = v;
    in_sums   = s;
    out_ready = r;
    #1;
    model_expect();
  endtask

  task automatic next_cycle();
    model_commit();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    in_valid  = 1'b0;
    out_ready = 1'b0;
    reset     = 1'b1;
    #2;
    reset     = 1'b0;
    mq.delete();
    exp_ovr   = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #1;
    n_checks++;
    if (out_valid !== 1'b0 || out_data !== '0 || out_index !== '0 || out_last !== 1'b0 ||
        overrun !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_initial: got v=%b d=%h i=%0d l=%b ovr=%b rdy=%b, want 0/0/0/0/0/1",
               out_valid, out_data, out_index, out_last, overrun, in_ready);
    end
    reset = 1'b0;
    @(posedge clk);
    #1;
    drive(1'b1, V1, 1'b1);
    next_cycle();
    drive(1'b1, V3, 1'b0);
    next_cycle();
    in_valid = 1'b0;
    #3;
    reset = 1'b1;
    #1;
    n_checks++;
    if (out_valid !== 1'b0 || out_data !== '0 || out_index !== '0 || out_last !== 1'b0 ||
        overrun !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_async: got v=%b d=%h i=%0d l=%b ovr=%b rdy=%b, want 0/0/0/0/0/1",
               out_valid, out_data, out_index, out_last, overrun, in_ready);
    end
    #2;
    reset = 1'b0;
    mq.delete();
    exp_ovr = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_single();
    for (int c = 0; c < 7; c++) begin
      drive(c == 0, V1, 1'b1);
      n_checks++;
      if (out_valid !== exp_valid) begin
        n_fail++; $display("FAIL single_valid c%0d: got %b want %b", c, out_valid, exp_valid);
      end
      if (exp_valid) begin
        n_checks++;
        if (out_data !== exp_data || out_index !== exp_idx || out_last !== exp_last) begin
          n_fail++;
          $display("FAIL single_beat c%0d: got %h/%0d/%b want %h/%0d/%b",
                   c, out_data, out_index, out_last, exp_data, exp_idx, exp_last);
        end
      end
      n_checks++;
      if (in_ready !== exp_ready || overrun !== exp_ovr) begin
        n_fail++;
        $display("FAIL single_ctrl c%0d: got rdy=%b ovr=%b want rdy=%b ovr=%b",
                 c, in_ready, overrun, exp_ready, exp_ovr);
      end
      next_cycle();
    end
  endtask

  task automatic test_backpressure();
    logic [SW-1:0] held_d;
    for (int c = 0; c < 12; c++) begin
      drive(c == 0, V1, !(c >= 2 && c <= 6));
      if (c == 2) held_d = out_data;
      n_checks++;
      if (out_valid !== exp_valid) begin
        n_fail++; $display("FAIL bp_valid c%0d: got %b want %b", c, out_valid, exp_valid);
      end
      if (exp_valid) begin
        n_checks++;
        if (out_data !== exp_data || out_index !== exp_idx || out_last !== exp_last) begin
          n_fail++;
          $display("FAIL bp_beat c%0d: got %h/%0d/%b want %h/%0d/%b",
                   c, out_data, out_index, out_last, exp_data, exp_idx, exp_last);
        end
      end
      if (c >= 2 && c <= 6) begin
        n_checks++;
        if (out_data !== held_d || out_data !== 18'h00001 || in_ready !== 1'b0) begin
          n_fail++;
          $display("FAIL bp_hold c%0d: got d=%h rdy=%b want d=00001 rdy=0", c, out_data, in_ready);
        end
      end
      n_checks++;
      if (in_ready !== exp_ready) begin
        n_fail++; $display("FAIL bp_ready c%0d: got %b want %b", c, in_ready, exp_ready);
      end
      next_cycle();
    end
  endtask

  task automatic test_back_to_back();
    int beats = 0;
    for (int c = 0; c < 11; c++) begin
      drive(c == 0 || c == 4, (c == 0) ? V1 : V2, 1'b1);
      if (out_valid && out_ready) beats++;
      n_checks++;
      if (out_valid !== exp_valid) begin
        n_fail++; $display("FAIL b2b_valid c%0d: got %b want %b", c, out_valid, exp_valid);
      end
      if (exp_valid) begin
        n_checks++;
        if (out_data !== exp_data || out_index !== exp_idx || out_last !== exp_last) begin
          n_fail++;
          $display("FAIL b2b_beat c%0d: got %h/%0d/%b want %h/%0d/%b",
                   c, out_data, out_index, out_last, exp_data, exp_idx, exp_last);
        end
      end
      n_checks++;
      if (in_ready !== exp_ready || overrun !== 1'b0) begin
        n_fail++;
        $display("FAIL b2b_ctrl c%0d: got rdy=%b ovr=%b want rdy=%b ovr=0", c, in_ready, overrun, exp_ready);
      end
      next_cycle();
    end
    n_checks++;
    if (beats != 8) begin
      n_fail++; $display("FAIL b2b_count: got %0d beats want 8", beats);
    end
  endtask

  task automatic test_overrun();
    for (int c = 0; c < 9; c++) begin
      drive(c == 0 || c == 2, (c == 0) ? V1 : V3, 1'b1);
      n_checks++;
      if (out_valid !== exp_valid) begin
        n_fail++; $display("FAIL ovr_valid c%0d: got %b want %b", c, out_valid, exp_valid);
      end
      if (exp_valid) begin
        n_checks++;
        if (out_data !== exp_data || out_index !== exp_idx || out_data === 18'h1AAAA) begin
          n_fail++;
          $display("FAIL ovr_beat c%0d: got %h/%0d want %h/%0d", c, out_data, out_index, exp_data, exp_idx);
        end
      end
      n_checks++;
      if (overrun !== exp_ovr) begin
        n_fail++; $display("FAIL ovr_flag c%0d: got %b want %b", c, overrun, exp_ovr);
      end
      next_cycle();
    end
    n_checks++;
    if (overrun !== 1'b1) begin
      n_fail++; $display("FAIL ovr_sticky: got %b want 1", overrun);
    end
  endtask

  task automatic test_reset_mid();
    for (int c = 0; c < 3; c++) begin
      drive(c == 0, V2, 1'b1);
      next_cycle();
    end
    n_checks++;
    if (out_valid !== 1'b1 || out_index !== 2'd2) begin
      n_fail++; $display("FAIL rmid_pre: got v=%b i=%0d want v=1 i=2", out_valid, out_index);
    end
    reset = 1'b1;
    #1;
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_last !== 1'b0) begin
      n_fail++;
      $display("FAIL rmid_async: got v=%b rdy=%b l=%b want 0/1/0", out_valid, in_ready, out_last);
    end
    #2;
    reset = 1'b0;
    mq.delete();
    exp_ovr = 1'b0;
    @(posedge clk);
    #1;
    for (int c = 0; c < 5; c++) begin
      drive(1'b0, V2, 1'b1);
      n_checks++;
      if (out_valid !== exp_valid || out_valid !== 1'b0) begin
        n_fail++; $display("FAIL rmid_post c%0d: got v=%b want 0", c, out_valid);
      end
      next_cycle();
    end
  endtask

  task automatic test_random();
    logic [SW*N-1:0] s;
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N; i++) s[i*SW +: SW] = SW'($urandom);
      drive($urandom_range(0, 9) < 3, s, $urandom_range(0, 9) < 7);
      n_checks++;
      if (out_valid !== exp_valid || in_ready !== exp_ready || overrun !== exp_ovr) begin
        n_fail++;
        $display("FAIL rand_ctrl c%0d: got v=%b rdy=%b ovr=%b want v=%b rdy=%b ovr=%b",
                 c, out_valid, in_ready, overrun, exp_valid, exp_ready, exp_ovr);
      end
      if (exp_valid) begin
        n_checks++;
        if (out_data !== exp_data || out_index !== exp_idx || out_last !== exp_last) begin
          n_fail++;
          $display("FAIL rand_beat c%0d: got %h/%0d/%b want %h/%0d/%b",
                   c, out_data, out_index, out_last, exp_data, exp_idx, exp_last);
        end
      end
      next_cycle();
    end
  endtask

  initial begin
    test_reset();
    test_single();
    do_reset();
    test_backpressure();
    do_reset();
    test_back_to_back();
    do_reset();
    test_overrun();
    do_reset();
    test_reset_mid();
    do_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
